// File: rtl/uart_rx_if.sv
// Signal bundle between a UART receiver (slave) and the logic that feeds and consumes it (master).
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_Type;
    logic [DATA_WIDTH-1:0] P_Data;
    logic                  Data_Valid;
    logic                  Par_Err;
    logic                  Stp_Err;

    modport slave  (input  RX_IN, PAR_EN, PAR_Type,
                    output P_Data, Data_Valid, Par_Err, Stp_Err);
    modport master (output RX_IN, PAR_EN, PAR_Type,
                    input  P_Data, Data_Valid, Par_Err, Stp_Err);
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: LSB-first, optional parity, one stop bit.
// Define UART_RX_MAJORITY_VOTE_EN to decide each bit by a 3-sample majority around the bit centre.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic     CLK,
    input  logic     RST,
    uart_rx_if.slave bus
);
    localparam int EW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [EW-1:0] SAMPLE    = EW'(OVERSAMPLE / 2);
    localparam logic [EW-1:0] EDGE_LAST = EW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic                  rx_meta;
    logic                  rx_s;
    logic [2:0]            state;
    logic [EW-1:0]         edge_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_en_l;
    logic                  par_type_l;
    logic                  par_mismatch;
    logic [DATA_WIDTH-1:0] p_data_r;
    logic                  data_valid_r;
    logic                  par_err_r;
    logic                  stp_err_r;
    logic                  bit_val;
    logic                  decide;
    logic                  wrap;
    logic                  exp_par;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.RX_IN;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [EW-1:0] DECIDE_AT = SAMPLE + EW'(1);

    logic samp_early;
    logic samp_mid;

    // The third vote is the live rx_s in the decision cycle itself.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            samp_early <= 1'b1;
            samp_mid   <= 1'b1;
        end else begin
            if (edge_cnt == SAMPLE - EW'(1)) samp_early <= rx_s;
            if (edge_cnt == SAMPLE)          samp_mid   <= rx_s;
        end
    end

    assign bit_val = (samp_early & samp_mid) | (samp_early & rx_s) | (samp_mid & rx_s);
`else
    localparam logic [EW-1:0] DECIDE_AT = SAMPLE;

    assign bit_val = rx_s;
`endif

    assign decide  = (edge_cnt == DECIDE_AT);
    assign wrap    = (edge_cnt == EDGE_LAST);
    assign exp_par = par_type_l ? ~^shift_reg : ^shift_reg;

    // The IDLE cycle that first sees the low line counts as edge 0 of the start bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            par_en_l     <= 1'b0;
            par_type_l   <= 1'b0;
            par_mismatch <= 1'b0;
            p_data_r     <= '0;
            data_valid_r <= 1'b0;
            par_err_r    <= 1'b0;
            stp_err_r    <= 1'b0;
        end else begin
            data_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    edge_cnt <= '0;
                    bit_cnt  <= '0;
                    if (!rx_s) begin
                        state        <= START;
                        edge_cnt     <= EW'(1);
                        par_en_l     <= bus.PAR_EN;
                        par_type_l   <= bus.PAR_Type;
                        par_mismatch <= 1'b0;
                    end
                end
                START: begin
                    edge_cnt <= wrap ? '0 : edge_cnt + EW'(1);
                    if (decide && bit_val) begin
                        state    <= IDLE;
                        edge_cnt <= '0;
                    end else if (wrap) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    edge_cnt <= wrap ? '0 : edge_cnt + EW'(1);
                    if (decide) shift_reg <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
                    if (wrap) begin
                        bit_cnt <= bit_cnt + BW'(1);
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            state   <= par_en_l ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    edge_cnt <= wrap ? '0 : edge_cnt + EW'(1);
                    if (decide) par_mismatch <= (bit_val != exp_par);
                    if (wrap) state <= STOP;
                end
                STOP: begin
                    edge_cnt <= wrap ? '0 : edge_cnt + EW'(1);
                    // Leave half a bit early so a back-to-back start edge is never missed.
                    if (decide) begin
                        p_data_r     <= shift_reg;
                        par_err_r    <= par_mismatch;
                        stp_err_r    <= ~bit_val;
                        data_valid_r <= bit_val & ~par_mismatch;
                        state        <= IDLE;
                        edge_cnt     <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    edge_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.P_Data     = p_data_r;
    assign bus.Data_Valid = data_valid_r;
    assign bus.Par_Err    = par_err_r;
    assign bus.Stp_Err    = stp_err_r;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level reference model compared every cycle, plus directed scenarios.
module tb_uart_rx;
    localparam int DW = 8;
    localparam int OV = 8;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int MV = 1;
`else
    localparam int MV = 0;
`endif
    localparam int LAT_NP = 2 + OV * (DW + 1) + OV / 2 + MV;
    localparam int LAT_P  = LAT_NP + OV;

    typedef struct {
        int unsigned   cyc;
        logic [DW-1:0] data;
        logic          pe;
        logic          se;
        logic          dv;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RST;
    int unsigned   cyc = 0;
    int            tests = 0;
    int            failed = 0;
    bit            chk_en = 1'b0;
    int unsigned   drive_cyc = 0;
    exp_t          exp_q[$];
    int unsigned   dv_cyc[$];
    logic [DW-1:0] exp_pd = '0;
    logic          exp_pe = 1'b0;
    logic          exp_se = 1'b0;
    logic          exp_dv = 1'b0;

    uart_rx_if #(.DATA_WIDTH(DW)) bus ();

    uart_rx #(.DATA_WIDTH(DW), .OVERSAMPLE(OV)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // A frame's result appears a fixed latency after the first clock edge that sees its start bit.
    task automatic pushFrame(input logic [DW-1:0] d, input bit pen, input bit ptype,
                             input bit par_bit, input bit stop_bit);
        exp_t e;
        int   ones;
        ones  = $countones(d) + int'(par_bit);
        e.cyc  = cyc + 1 + (pen ? LAT_P : LAT_NP);
        e.data = d;
        e.pe   = pen && (((ones + int'(ptype)) % 2) != 0);
        e.se   = !stop_bit;
        e.dv   = !e.pe && stop_bit;
        exp_q.push_back(e);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (RST !== 1'b1) begin
            exp_q.delete();
            exp_pd = '0;
            exp_pe = 1'b0;
            exp_se = 1'b0;
            exp_dv = 1'b0;
        end else begin
            exp_dv = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e      = exp_q.pop_front();
                exp_pd = e.data;
                exp_pe = e.pe;
                exp_se = e.se;
                exp_dv = e.dv;
            end
        end
        if (bus.Data_Valid === 1'b1) dv_cyc.push_back(cyc);
        if (chk_en) begin
            checkOutput("Data_Valid", 32'(bus.Data_Valid), 32'(exp_dv));
            checkOutput("P_Data",     32'(bus.P_Data),     32'(exp_pd));
            checkOutput("Par_Err",    32'(bus.Par_Err),    32'(exp_pe));
            checkOutput("Stp_Err",    32'(bus.Stp_Err),    32'(exp_se));
        end
    end

    // Every stimulus task starts and ends 1 time unit after a rising edge.
    task automatic idle(input int n);
        bus.RX_IN = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic sendBit(input logic b, input bit glitch);
        bus.RX_IN = b;
        if (glitch) begin
            repeat (OV / 2) @(posedge CLK);
            #1 bus.RX_IN = ~b;
            @(posedge CLK);
            #1 bus.RX_IN = b;
            repeat (OV / 2 - 1) @(posedge CLK);
            #1;
        end else begin
            repeat (OV) @(posedge CLK);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [DW-1:0] d, input bit pen, input bit ptype,
                                 input bit par_bit, input bit stop_bit, input bit toggle,
                                 input int glitch_idx);
        bus.PAR_EN   = pen;
        bus.PAR_Type = ptype;
        drive_cyc    = cyc;
        pushFrame(d, pen, ptype, par_bit, stop_bit);
        sendBit(1'b0, 1'b0);
        if (toggle) begin
            bus.PAR_EN   = ~pen;
            bus.PAR_Type = ~ptype;
        end
        for (int i = 0; i < DW; i++) sendBit(d[i], i == glitch_idx);
        if (pen) sendBit(par_bit, 1'b0);
        sendBit(stop_bit, 1'b0);
    endtask

    initial begin
        int            n0;
        logic [DW-1:0] partial;
        bus.RX_IN    = 1'b1;
        bus.PAR_EN   = 1'b0;
        bus.PAR_Type = 1'b0;
        RST = 1'b1;
        #2 RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("reset P_Data",     32'(bus.P_Data),     32'h0);
        checkOutput("reset Data_Valid", 32'(bus.Data_Valid), 32'h0);
        checkOutput("reset Par_Err",    32'(bus.Par_Err),    32'h0);
        checkOutput("reset Stp_Err",    32'(bus.Stp_Err),    32'h0);
        RST    = 1'b1;
        chk_en = 1'b1;
        idle(4);

        // Even parity, good frame; latency pinned to 2 + 8*10 + 4 (+1 with majority vote).
        n0 = dv_cyc.size();
        applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        idle(2 * OV);
        checkOutput("t1 pulse count", 32'(dv_cyc.size() - n0), 32'd1);
        if (dv_cyc.size() > n0)
            checkOutput("t1 latency", 32'(dv_cyc[dv_cyc.size() - 1] - drive_cyc - 1), 32'(86 + MV));
        checkOutput("t1 P_Data",  32'(bus.P_Data),  32'hA5);
        checkOutput("t1 Par_Err", 32'(bus.Par_Err), 32'h0);
        checkOutput("t1 Stp_Err", 32'(bus.Stp_Err), 32'h0);

        // Odd parity expected but 0 sent for 0xA5.
        n0 = dv_cyc.size();
        applyStimulus(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1);
        idle(2 * OV);
        checkOutput("t2 pulse count", 32'(dv_cyc.size() - n0), 32'd0);
        checkOutput("t2 P_Data",  32'(bus.P_Data),  32'hA5);
        checkOutput("t2 Par_Err", 32'(bus.Par_Err), 32'h1);

        // Stop bit low, then the same word framed correctly.
        n0 = dv_cyc.size();
        applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        idle(2 * OV);
        checkOutput("t3 bad-stop pulse count", 32'(dv_cyc.size() - n0), 32'd0);
        checkOutput("t3 Stp_Err set", 32'(bus.Stp_Err), 32'h1);
        applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        idle(2 * OV);
        checkOutput("t3 pulse count", 32'(dv_cyc.size() - n0), 32'd1);
        checkOutput("t3 Stp_Err clear", 32'(bus.Stp_Err), 32'h0);

        // Three-cycle low glitch is a false start and leaves outputs alone.
        n0 = dv_cyc.size();
        bus.RX_IN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        idle(2 * OV);
        checkOutput("t4 false-start pulse count", 32'(dv_cyc.size() - n0), 32'd0);
        checkOutput("t4 P_Data held", 32'(bus.P_Data), 32'h3C);
        applyStimulus(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        idle(2 * OV);
        checkOutput("t4 P_Data", 32'(bus.P_Data), 32'h81);

        // Back-to-back frames with no idle bit between them.
        n0 = dv_cyc.size();
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        applyStimulus(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        applyStimulus(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        idle(2 * OV);
        checkOutput("t5 pulse count", 32'(dv_cyc.size() - n0), 32'd3);
        if (dv_cyc.size() == n0 + 3) begin
            checkOutput("t5 spacing 1", 32'(dv_cyc[n0 + 1] - dv_cyc[n0]),     32'd80);
            checkOutput("t5 spacing 2", 32'(dv_cyc[n0 + 2] - dv_cyc[n0 + 1]), 32'd80);
        end

        // Reset during bit 4 of 0xF0 aborts it; then 0x0F (glitched at a sample point when voting).
        n0 = dv_cyc.size();
        partial = 8'hF0;
        bus.PAR_EN = 1'b0;
        sendBit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) sendBit(partial[i], 1'b0);
        bus.RX_IN = partial[4];
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        #1;
        checkOutput("t6 reset P_Data", 32'(bus.P_Data), 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        bus.RX_IN = 1'b1;
        RST = 1'b1;
        idle(OV);
        applyStimulus(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, (MV == 1) ? 2 : -1);
        idle(2 * OV);
        checkOutput("t6 pulse count", 32'(dv_cyc.size() - n0), 32'd1);
        checkOutput("t6 P_Data", 32'(bus.P_Data), 32'h0F);

        // Random frames: random parity mode, corrupted parity/stop, mid-frame config changes, random gaps.
        for (int n = 0; n < 40; n++) begin
            logic [DW-1:0] d;
            bit            pen;
            bit            pt;
            bit            pbit;
            bit            sb;
            bit            tog;
            int            gidx;
            d    = DW'($urandom);
            pen  = 1'($urandom_range(0, 1));
            pt   = 1'($urandom_range(0, 1));
            pbit = (pt ? ~^d : ^d) ^ ($urandom_range(0, 4) == 0);
            sb   = ($urandom_range(0, 5) != 0);
            tog  = ($urandom_range(0, 3) == 0);
            gidx = (MV == 1) ? int'($urandom_range(0, DW - 1)) : -1;
            applyStimulus(d, pen, pt, pbit, sb, tog, gidx);
            idle(sb ? int'($urandom_range(0, 12)) : OV + int'($urandom_range(0, 4)));
        end

        idle(2 * OV);
        checkOutput("all expected frames seen", 32'(exp_q.size()), 32'd0);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
